// File: rtl/prog_loader.sv
// Boot-time program loader: receives a framed byte stream (length, payload,
// checksum), writes the payload into memory and holds the CPU in reset until a frame loads cleanly.
module prog_loader #(
  parameter int AWIDTH     = 5,
  parameter int DWIDTH     = 8,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [DWIDTH-1:0] s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data,
  output logic              cpu_rst,
  output logic              done,
  output logic [1:0]        err_code
);

  // Length/count width must hold both a full stream byte and the capacity value itself.
  localparam int CW = (DWIDTH > AWIDTH + 1) ? DWIDTH : AWIDTH + 1;
  localparam logic [CW-1:0]     CAPACITY = CW'(2 ** AWIDTH);
  localparam logic [AWIDTH-1:0] START    = AWIDTH'(START_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_RUN,
    S_ERR
  } state_t;

  state_t              state_reg,    state_next;
  logic [CW-1:0]       len_reg,      len_next;
  logic [CW-1:0]       count_reg,    count_next;
  logic [DWIDTH-1:0]   sum_reg,      sum_next;
  logic [AWIDTH-1:0]   addr_reg,     addr_next;
  logic                mem_wr_reg,   mem_wr_next;
  logic [AWIDTH-1:0]   mem_addr_reg, mem_addr_next;
  logic [DWIDTH-1:0]   mem_data_reg, mem_data_next;
  logic                cpu_rst_reg,  cpu_rst_next;
  logic                done_reg,     done_next;
  logic [1:0]          err_code_reg, err_code_next;

  logic                ready_state;
  logic                accept;
  logic [CW-1:0]       data_ext;
  logic                bad_len;

  assign ready_state = (state_reg == S_IDLE) || (state_reg == S_LOAD) || (state_reg == S_CHECK);
  // Nothing is taken while reset or reload is asserted, so a restart never eats a byte.
  assign s_ready  = ready_state && !rst && !reload;
  assign accept   = s_valid && s_ready;
  assign data_ext = CW'(s_data);
  assign bad_len  = (data_ext == '0) || (data_ext > CAPACITY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      len_reg      <= '0;
      count_reg    <= '0;
      sum_reg      <= '0;
      addr_reg     <= START;
      mem_wr_reg   <= 1'b0;
      mem_addr_reg <= START;
      mem_data_reg <= '0;
      cpu_rst_reg  <= 1'b1;
      done_reg     <= 1'b0;
      err_code_reg <= 2'd0;
    end else begin
      state_reg    <= state_next;
      len_reg      <= len_next;
      count_reg    <= count_next;
      sum_reg      <= sum_next;
      addr_reg     <= addr_next;
      mem_wr_reg   <= mem_wr_next;
      mem_addr_reg <= mem_addr_next;
      mem_data_reg <= mem_data_next;
      cpu_rst_reg  <= cpu_rst_next;
      done_reg     <= done_next;
      err_code_reg <= err_code_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    len_next      = len_reg;
    count_next    = count_reg;
    sum_next      = sum_reg;
    addr_next     = addr_reg;
    mem_wr_next   = 1'b0;
    mem_addr_next = mem_addr_reg;
    mem_data_next = mem_data_reg;
    err_code_next = err_code_reg;

    unique case (state_reg)
      S_IDLE: begin
        if (accept) begin
          if (bad_len) begin
            state_next    = S_ERR;
            err_code_next = 2'd1;
          end else begin
            len_next   = data_ext;
            count_next = '0;
            sum_next   = '0;
            addr_next  = START;
            state_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        if (accept) begin
          // Write goes out registered, one cycle after the byte is taken.
          mem_wr_next   = 1'b1;
          mem_addr_next = addr_reg;
          mem_data_next = s_data;
          sum_next      = sum_reg + s_data;
          count_next    = count_reg + CW'(1);
          addr_next     = addr_reg + AWIDTH'(1);
          if (count_reg + CW'(1) == len_reg) begin
            state_next = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (accept) begin
          if (s_data == sum_reg) begin
            state_next = S_RUN;
          end else begin
            state_next    = S_ERR;
            err_code_next = 2'd2;
          end
        end
      end
      S_RUN, S_ERR: begin
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    if (reload) begin
      state_next    = S_IDLE;
      count_next    = '0;
      sum_next      = '0;
      err_code_next = 2'd0;
    end

    // Registered from the next state so they track RUN exactly, with no stale cycle after leaving it.
    cpu_rst_next = (state_next != S_RUN);
    done_next    = (state_next == S_RUN);
  end

  assign mem_wr   = mem_wr_reg;
  assign mem_addr = mem_addr_reg;
  assign mem_data = mem_data_reg;
  assign cpu_rst  = cpu_rst_reg;
  assign done     = done_reg;
  assign err_code = err_code_reg;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: two instances (START_ADDR 0 and 30) share
// one stream driver; expected memory writes are queued per instance as frames are sent.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sel = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       reload = 1'b0;

  logic       v0, v1, rdy0, rdy1, cur_ready;
  logic       mw0, mw1, cr0, cr1, dn0, dn1;
  logic [4:0] ma0, ma1;
  logic [7:0] md0, md1;
  logic [1:0] ec0, ec1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [7:0]  fr[$];

  always #5 clk = ~clk;

  assign v0 = s_valid & ~sel;
  assign v1 = s_valid & sel;
  assign cur_ready = sel ? rdy1 : rdy0;

  prog_loader #(.AWIDTH(5), .DWIDTH(8), .START_ADDR(0)) dut (
    .clk(clk), .rst(rst), .s_valid(v0), .s_data(s_data), .s_ready(rdy0),
    .reload(reload), .mem_wr(mw0), .mem_addr(ma0), .mem_data(md0),
    .cpu_rst(cr0), .done(dn0), .err_code(ec0)
  );

  prog_loader #(.AWIDTH(5), .DWIDTH(8), .START_ADDR(30)) dut30 (
    .clk(clk), .rst(rst), .s_valid(v1), .s_data(s_data), .s_ready(rdy1),
    .reload(reload), .mem_wr(mw1), .mem_addr(ma1), .mem_data(md1),
    .cpu_rst(cr1), .done(dn1), .err_code(ec1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic exp_wr(input int which, input int addr, input logic [7:0] data);
    if (which == 0) q0.push_back({8'(addr), data});
    else            q1.push_back({8'(addr), data});
  endtask

  // Drive one byte and hold it until the selected loader takes it.
  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = b;
    #1;
    while (!cur_ready) begin
      @(negedge clk);
      #1;
      n++;
      if (n > 50) begin
        chk("ready_timeout", 32'(cur_ready), 1);
        s_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic send_list(input logic [7:0] bl[$], input int gap);
    foreach (bl[i]) begin
      send(bl[i]);
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_reload();
    @(negedge clk);
    s_valid = 1'b1;
    s_data  = 8'h05;
    reload  = 1'b1;
    #1;
    chk("ready_in_reload", 32'(cur_ready), 0);
    @(negedge clk);
    reload  = 1'b0;
    s_valid = 1'b0;
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && mw0) begin
      if (q0.size() == 0) chk("wr0_unexpected", 32'(mw0), 0);
      else begin
        logic [15:0] e;
        e = q0.pop_front();
        chk("wr0_addr", 32'(ma0), 32'(e[15:8]));
        chk("wr0_data", 32'(md0), 32'(e[7:0]));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && mw1) begin
      if (q1.size() == 0) chk("wr1_unexpected", 32'(mw1), 0);
      else begin
        logic [15:0] e;
        e = q1.pop_front();
        chk("wr1_addr", 32'(ma1), 32'(e[15:8]));
        chk("wr1_data", 32'(md1), 32'(e[7:0]));
      end
    end
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    s_valid = 1'b1;
    #1;
    chk("rst_ready", 32'(rdy0), 0);
    chk("rst_mem_wr", 32'(mw0), 0);
    chk("rst_mem_addr", 32'(ma0), 0);
    chk("rst_mem_addr30", 32'(ma1), 30);
    chk("rst_mem_data", 32'(md0), 0);
    chk("rst_cpu_rst", 32'(cr0), 1);
    chk("rst_done", 32'(dn0), 0);
    chk("rst_err", 32'(ec0), 0);
    s_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(rdy0), 1);

    // 1: good frame
    sel = 1'b0;
    exp_wr(0, 0, 8'h11); exp_wr(0, 1, 8'h22); exp_wr(0, 2, 8'h33);
    fr = {8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_list(fr, 0);
    chk("t1_done", 32'(dn0), 1);
    chk("t1_cpu_rst", 32'(cr0), 0);
    @(negedge clk); s_valid = 1'b1; #1;
    chk("t1_run_ready", 32'(rdy0), 0);
    repeat (2) @(negedge clk);
    s_valid = 1'b0;
    chk("t1_q_empty", 32'(q0.size()), 0);
    chk("t1_still_run", 32'(dn0), 1);
    do_reload();
    chk("t1_reload_cpu_rst", 32'(cr0), 1);
    chk("t1_reload_done", 32'(dn0), 0);
    chk("t1_reload_ready", 32'(rdy0), 1);

    // 2: checksum mismatch
    exp_wr(0, 0, 8'h10); exp_wr(0, 1, 8'h20);
    fr = {8'h02, 8'h10, 8'h20, 8'h31};
    send_list(fr, 0);
    chk("t2_err", 32'(ec0), 2);
    chk("t2_cpu_rst", 32'(cr0), 1);
    chk("t2_done", 32'(dn0), 0);
    chk("t2_ready", 32'(rdy0), 0);
    repeat (2) @(negedge clk);
    chk("t2_err_sticky", 32'(ec0), 2);
    chk("t2_q_empty", 32'(q0.size()), 0);
    do_reload();
    chk("t2_err_cleared", 32'(ec0), 0);

    // 3: bad lengths, then the largest legal length
    send(8'h00);
    chk("t3_len0_err", 32'(ec0), 1);
    do_reload();
    send(8'h21);
    chk("t3_len33_err", 32'(ec0), 1);
    chk("t3_cpu_rst", 32'(cr0), 1);
    do_reload();
    fr = {8'h20};
    for (int i = 0; i < 32; i++) begin
      fr.push_back(8'(i));
      exp_wr(0, i, 8'(i));
    end
    fr.push_back(8'hF0);
    send_list(fr, 0);
    chk("t3_len32_done", 32'(dn0), 1);
    do_reload();

    // 4: START_ADDR=30 wraps after address 31
    sel = 1'b1;
    exp_wr(1, 30, 8'h01); exp_wr(1, 31, 8'h02); exp_wr(1, 0, 8'h03); exp_wr(1, 1, 8'h04);
    fr = {8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
    send_list(fr, 0);
    chk("t4_done", 32'(dn1), 1);
    chk("t4_cpu_rst", 32'(cr1), 0);
    @(negedge clk);
    chk("t4_q_empty", 32'(q1.size()), 0);
    sel = 1'b0;

    // 5: s_valid toggled every other cycle
    exp_wr(0, 0, 8'h11); exp_wr(0, 1, 8'h22); exp_wr(0, 2, 8'h33);
    fr = {8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_list(fr, 1);
    chk("t5_done", 32'(dn0), 1);
    chk("t5_err", 32'(ec0), 0);
    do_reload();

    // 6: reload mid-load, then full frame restarts at address 0
    exp_wr(0, 0, 8'h11); exp_wr(0, 1, 8'h22);
    fr = {8'h03, 8'h11, 8'h22};
    send_list(fr, 0);
    do_reload();
    chk("t6_no_done", 32'(dn0), 0);
    exp_wr(0, 0, 8'h11); exp_wr(0, 1, 8'h22); exp_wr(0, 2, 8'h33);
    fr = {8'h03, 8'h11, 8'h22, 8'h33, 8'h66};
    send_list(fr, 0);
    chk("t6_done", 32'(dn0), 1);
    do_reload();
    chk("t6_reload_cpu_rst", 32'(cr0), 1);
    chk("t6_reload_ready", 32'(rdy0), 1);

    // Async reset mid-frame
    exp_wr(0, 0, 8'h44); exp_wr(0, 1, 8'h55);
    fr = {8'h03, 8'h44, 8'h55};
    send_list(fr, 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_addr", 32'(ma0), 0);
    chk("arst_cpu_rst", 32'(cr0), 1);
    chk("arst_ready", 32'(rdy0), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("end_q0_empty", 32'(q0.size()), 0);
    chk("end_q1_empty", 32'(q1.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
